// File: rtl/sisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sisc_pkg
// Purpose  : Shared opcodes, ALU functions, FSM states and datapath codes.
// Revision : 1.0 - initial release
// ============================================================================
package sisc_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_REG_OP = 4'd1,
    OP_REG_IM = 4'd2,
    OP_SWAP   = 4'd3,
    OP_BRA    = 4'd4,
    OP_BRR    = 4'd5,
    OP_BNE    = 4'd6,
    OP_BNR    = 4'd7,
    OP_LOD    = 4'd8,
    OP_STR    = 4'd9,
    OP_HLT    = 4'd15
  } op_e;

  typedef enum logic [3:0] {
    FN_ADD = 4'd0,
    FN_SUB = 4'd1,
    FN_AND = 4'd2,
    FN_OR  = 4'd3,
    FN_XOR = 4'd4,
    FN_NOT = 4'd5,
    FN_SHL = 4'd6,
    FN_SHR = 4'd7
  } func_e;

  typedef enum logic [2:0] {
    ST_START0    = 3'd0,
    ST_START1    = 3'd1,
    ST_FETCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_EXECUTE   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_RSA = 2'b10;
  localparam logic [1:0] WB_RSB = 2'b11;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [1:0] MODE_RR   = 2'b00;
  localparam logic [1:0] MODE_RI   = 2'b01;
  localparam logic [1:0] MODE_ADDR = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sisc_exec_ctrl_if
// Purpose  : Datapath-facing bus of the execution/control core.
// Revision : 1.0 - initial release
// ============================================================================
interface sisc_exec_ctrl_if;
  logic [31:0] instr;
  logic [15:0] pc;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [3:0]  stat_in;
  logic [31:0] alu_result;
  logic [3:0]  stat_out;
  logic        stat_en;
  logic [15:0] br_addr;
  logic        rf_we;
  logic        wr_sel;
  logic        rb_sel;
  logic [1:0]  wb_sel;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        pc_rst;
  logic        mm_sel;
  logic        dm_we;

  // master = control core, slave = surrounding datapath
  modport master (
    input  instr, pc, rsa, rsb, stat_in,
    output alu_result, stat_out, stat_en, br_addr, rf_we, wr_sel, rb_sel,
           wb_sel, ir_load, pc_write, pc_sel, pc_rst, mm_sel, dm_we
  );

  modport slave (
    output instr, pc, rsa, rsb, stat_in,
    input  alu_result, stat_out, stat_en, br_addr, rf_we, wr_sel, rb_sel,
           wb_sel, ir_load, pc_write, pc_sel, pc_rst, mm_sel, dm_we
  );
endinterface
`default_nettype wire

// File: rtl/sisc_alu.sv
`default_nettype none
// ============================================================================
// Module   : sisc_alu
// Purpose  : 32-bit ALU with {C,V,N,Z} generation and registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_alu
  import sisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic        load,
  input  logic [1:0]  mode,
  input  logic [3:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [15:0] imm,
  output logic [31:0] result_q,
  output logic [3:0]  stat_q
);

  logic [31:0] result_d;
  logic [3:0]  stat_d;
  logic [31:0] b_op;
  logic [31:0] addend;
  logic [32:0] sum;
  logic [31:0] res;
  logic        c;
  logic        v;
  func_e       fn;

  always_comb begin
    b_op   = (mode == MODE_RR) ? b : sext16(imm);
    // address and pass modes always use the adder path
    fn     = mode[1] ? FN_ADD : func_e'(func);
    addend = (fn == FN_SUB) ? ~b_op : b_op;
    sum    = {1'b0, a} + {1'b0, addend} + {32'd0, (fn == FN_SUB)};
    res    = sum[31:0];
    c      = sum[32];
    v      = (a[31] == addend[31]) && (res[31] != a[31]);
    case (fn)
      FN_AND:  begin res = a & b_op;            c = 1'b0;  v = 1'b0; end
      FN_OR:   begin res = a | b_op;            c = 1'b0;  v = 1'b0; end
      FN_XOR:  begin res = a ^ b_op;            c = 1'b0;  v = 1'b0; end
      FN_NOT:  begin res = ~a;                  c = 1'b0;  v = 1'b0; end
      FN_SHL:  begin res = {a[30:0], 1'b0};     c = a[31]; v = 1'b0; end
      FN_SHR:  begin res = {1'b0, a[31:1]};     c = a[0];  v = 1'b0; end
      default: ;
    endcase
    if (mode == MODE_PASS) begin
      res = a;
    end

    result_d = result_q;
    stat_d   = stat_q;
    if (load) begin
      result_d = res;
      if (!mode[1]) begin
        stat_d[FLAG_C] = c;
        stat_d[FLAG_V] = v;
        stat_d[FLAG_N] = res[31];
        stat_d[FLAG_Z] = (res == 32'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      result_q <= 32'd0;
      stat_q   <= 4'd0;
    end else begin
      result_q <= result_d;
      stat_q   <= stat_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sisc_exec_ctrl
// Purpose  : Five-cycle control FSM, ALU and branch-target adder of SISC.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_exec_ctrl
  import sisc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_f,
  sisc_exec_ctrl_if.master        bus
);

  state_e      state_q;
  state_e      state_d;
  op_e         op;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic        br_taken;
  logic        is_rel;
  logic [1:0]  alu_mode;
  logic [31:0] alu_result;
  logic [3:0]  stat_out;
  logic        unused_fields;

  logic        stat_en, rf_we, wr_sel, rb_sel, ir_load;
  logic        pc_write, pc_sel, pc_rst, mm_sel, dm_we;
  logic [1:0]  wb_sel;

  assign op            = op_e'(bus.instr[31:28]);
  assign mm            = bus.instr[27:24];
  assign imm           = bus.instr[15:0];
  assign unused_fields = ^bus.instr[23:16];

  assign is_rel   = (op == OP_BRR) || (op == OP_BNR);
  assign br_taken = (((op == OP_BRA) || (op == OP_BRR)) && ((bus.stat_in & mm) != 4'd0)) ||
                    (((op == OP_BNE) || (op == OP_BNR)) && ((bus.stat_in & mm) == 4'd0));
  assign bus.br_addr = is_rel ? (bus.pc + imm) : imm;

  always_comb begin
    case (op)
      OP_REG_OP:     alu_mode = MODE_RR;
      OP_REG_IM:     alu_mode = MODE_RI;
      OP_LOD, OP_STR: alu_mode = MODE_ADDR;
      default:       alu_mode = MODE_PASS;
    endcase
  end

  sisc_alu u_alu (
    .clk      (clk),
    .rst_f    (rst_f),
    .load     (state_q == ST_EXECUTE),
    .mode     (alu_mode),
    .func     (mm),
    .a        (bus.rsa),
    .b        (bus.rsb),
    .imm      (imm),
    .result_q (alu_result),
    .stat_q   (stat_out)
  );

  always_comb begin
    state_d  = state_q;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wr_sel   = 1'b0;
    rb_sel   = 1'b0;
    wb_sel   = WB_ALU;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    pc_rst   = rst_f && (state_q == ST_START0);

    if (rst_f) begin
      state_d = ST_START0;
    end else begin
      // operand selects hold for the whole instruction after decode
      if ((state_q == ST_DECODE) || (state_q == ST_EXECUTE) ||
          (state_q == ST_MEM) || (state_q == ST_WRITEBACK)) begin
        mm_sel = ((op == OP_LOD) || (op == OP_STR)) && mm[3];
        rb_sel = (op == OP_STR) || (op == OP_SWAP);
      end
      case (state_q)
        ST_START0: state_d = ST_START1;
        ST_START1: state_d = ST_FETCH;
        ST_FETCH: begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
        ST_DECODE: begin
          if (br_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
          end
          state_d = (op == OP_HLT) ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: state_d = ST_MEM;
        ST_MEM: begin
          stat_en = (op == OP_REG_OP) || (op == OP_REG_IM);
          dm_we   = (op == OP_STR);
          if (op == OP_SWAP) begin
            rf_we  = 1'b1;
            wr_sel = 1'b1;
            wb_sel = WB_RSB;
          end
          state_d = ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if ((op == OP_REG_OP) || (op == OP_REG_IM) || (op == OP_SWAP)) begin
            rf_we  = 1'b1;
            wb_sel = WB_ALU;
          end else if (op == OP_LOD) begin
            rf_we  = 1'b1;
            wb_sel = WB_DM;
          end
          state_d = ST_FETCH;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_START0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= ST_START0;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.alu_result = alu_result;
  assign bus.stat_out   = stat_out;
  assign bus.stat_en    = stat_en;
  assign bus.rf_we      = rf_we;
  assign bus.wr_sel     = wr_sel;
  assign bus.rb_sel     = rb_sel;
  assign bus.wb_sel     = wb_sel;
  assign bus.ir_load    = ir_load;
  assign bus.pc_write   = pc_write;
  assign bus.pc_sel     = pc_sel;
  assign bus.pc_rst     = pc_rst;
  assign bus.mm_sel     = mm_sel;
  assign bus.dm_we      = dm_we;

endmodule
`default_nettype wire

// File: tb/tb_sisc_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisc_exec_ctrl
// Purpose  : Directed self-checking bench for the SISC execution/control core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sisc_exec_ctrl;

  logic clk = 1'b0;
  logic rst_f = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sisc_exec_ctrl_if bus();

  sisc_exec_ctrl dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] p, input logic [3:0] s);
    bus.instr = i; bus.rsa = a; bus.rsb = b; bus.pc = p; bus.stat_in = s;
  endtask

  task automatic test_reset();
    rst_f = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 16'h0, 4'h0);
    step(); step();
    total++; if (bus.pc_rst !== 1'b1) begin bad++; $display("FAIL reset_pc_rst got=%b want=1", bus.pc_rst); end
    total++; if (bus.alu_result !== 32'h0) begin bad++; $display("FAIL reset_alu got=%h want=0", bus.alu_result); end
    total++; if (bus.ir_load !== 1'b0) begin bad++; $display("FAIL reset_ir_load got=%b want=0", bus.ir_load); end
    rst_f = 1'b0;
    step();
    total++; if (bus.ir_load !== 1'b0 || bus.pc_rst !== 1'b0) begin bad++; $display("FAIL start1_ctrl got ir=%b rst=%b want 0 0", bus.ir_load, bus.pc_rst); end
    step();
    total++; if (bus.ir_load !== 1'b1 || bus.pc_write !== 1'b1 || bus.pc_sel !== 1'b0) begin
      bad++; $display("FAIL fetch_ctrl got ir=%b pw=%b ps=%b want 1 1 0", bus.ir_load, bus.pc_write, bus.pc_sel); end
  endtask

  task automatic test_alu();
    logic [31:0] t_instr [6] = '{32'h10123000, 32'h11123000, 32'h2012FFFF,
                                 32'h14123000, 32'h27120000, 32'h16123000};
    logic [31:0] t_a     [6] = '{32'h7FFFFFFF, 32'h5, 32'h1, 32'hF0F0F0F0, 32'h3, 32'h80000000};
    logic [31:0] t_b     [6] = '{32'h1, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [31:0] t_res   [6] = '{32'h80000000, 32'h0, 32'h0, 32'h0F0F0F0F, 32'h1, 32'h0};
    logic [3:0]  t_stat  [6] = '{4'b0110, 4'b1001, 4'b1001, 4'b0000, 4'b1000, 4'b1001};
    for (int k = 0; k < 6; k++) begin
      drive(t_instr[k], t_a[k], t_b[k], 16'h0, 4'h0);
      step(); step(); step();
      total++; if (bus.alu_result !== t_res[k]) begin bad++; $display("FAIL alu_result[%0d] got=%h want=%h", k, bus.alu_result, t_res[k]); end
      total++; if (bus.stat_out !== t_stat[k]) begin bad++; $display("FAIL alu_stat[%0d] got=%b want=%b", k, bus.stat_out, t_stat[k]); end
      total++; if (bus.stat_en !== 1'b1 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL mem_ctrl[%0d] got en=%b we=%b want 1 0", k, bus.stat_en, bus.rf_we); end
      step();
      total++; if (bus.rf_we !== 1'b1 || bus.wb_sel !== 2'b00 || bus.stat_en !== 1'b0) begin
        bad++; $display("FAIL wb_ctrl[%0d] got we=%b sel=%b en=%b want 1 00 0", k, bus.rf_we, bus.wb_sel, bus.stat_en); end
      step();
      total++; if (bus.ir_load !== 1'b1) begin bad++; $display("FAIL refetch[%0d] got=%b want=1", k, bus.ir_load); end
    end
  endtask

  task automatic test_branch();
    // BNE on clear flags: taken, absolute target
    drive(32'h61000020, 32'h0, 32'h0, 16'h0010, 4'b0000);
    step();
    total++; if (bus.pc_write !== 1'b1 || bus.pc_sel !== 1'b1) begin bad++; $display("FAIL bne_taken got pw=%b ps=%b want 1 1", bus.pc_write, bus.pc_sel); end
    total++; if (bus.br_addr !== 16'h0020) begin bad++; $display("FAIL bne_addr got=%h want=0020", bus.br_addr); end
    step(); step();
    total++; if (bus.stat_out !== 4'b1001 || bus.stat_en !== 1'b0) begin bad++; $display("FAIL branch_no_flags got st=%b en=%b want 1001 0", bus.stat_out, bus.stat_en); end
    step(); step();
    drive(32'h61000020, 32'h0, 32'h0, 16'h0010, 4'b0001);
    step();
    total++; if (bus.pc_write !== 1'b0) begin bad++; $display("FAIL bne_not_taken got pw=%b want 0", bus.pc_write); end
    step(); step(); step(); step();
    drive(32'h5100FFFE, 32'h0, 32'h0, 16'h0010, 4'b0001);
    step();
    total++; if (bus.pc_write !== 1'b1 || bus.pc_sel !== 1'b1) begin bad++; $display("FAIL brr_taken got pw=%b ps=%b want 1 1", bus.pc_write, bus.pc_sel); end
    total++; if (bus.br_addr !== 16'h000E) begin bad++; $display("FAIL brr_addr got=%h want=000e", bus.br_addr); end
    step(); step(); step(); step();
  endtask

  task automatic test_mem();
    drive(32'h98400010, 32'h0, 32'h0, 16'h0, 4'h0);
    step(); step(); step();
    total++; if (bus.dm_we !== 1'b1 || bus.mm_sel !== 1'b1 || bus.rb_sel !== 1'b1 || bus.rf_we !== 1'b0) begin
      bad++; $display("FAIL str_mem got we=%b mm=%b rb=%b rf=%b want 1 1 1 0", bus.dm_we, bus.mm_sel, bus.rb_sel, bus.rf_we); end
    step();
    total++; if (bus.rf_we !== 1'b0 || bus.dm_we !== 1'b0) begin bad++; $display("FAIL str_wb got rf=%b dm=%b want 0 0", bus.rf_we, bus.dm_we); end
    step();
    drive(32'h80120004, 32'h100, 32'h0, 16'h0, 4'h0);
    step(); step(); step();
    total++; if (bus.alu_result !== 32'h104 || bus.mm_sel !== 1'b0) begin bad++; $display("FAIL lod_addr got=%h mm=%b want 104 0", bus.alu_result, bus.mm_sel); end
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.wb_sel !== 2'b01) begin bad++; $display("FAIL lod_wb got we=%b sel=%b want 1 01", bus.rf_we, bus.wb_sel); end
    step();
  endtask

  task automatic test_swap();
    drive(32'h30120000, 32'hA, 32'hB, 16'h0, 4'h0);
    step(); step(); step();
    total++; if (bus.rf_we !== 1'b1 || bus.wr_sel !== 1'b1 || bus.wb_sel !== 2'b11 || bus.rb_sel !== 1'b1) begin
      bad++; $display("FAIL swap_mem got we=%b wr=%b sel=%b rb=%b want 1 1 11 1", bus.rf_we, bus.wr_sel, bus.wb_sel, bus.rb_sel); end
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.wr_sel !== 1'b0 || bus.wb_sel !== 2'b00 || bus.alu_result !== 32'hA) begin
      bad++; $display("FAIL swap_wb got we=%b wr=%b sel=%b res=%h want 1 0 00 a", bus.rf_we, bus.wr_sel, bus.wb_sel, bus.alu_result); end
    step();
  endtask

  task automatic test_mid_reset();
    drive(32'h10123000, 32'h1, 32'h1, 16'h0, 4'h0);
    step(); step();
    rst_f = 1'b1;
    step();
    total++; if (bus.alu_result !== 32'h0 || bus.stat_out !== 4'h0 || bus.pc_rst !== 1'b1) begin
      bad++; $display("FAIL mid_reset got res=%h st=%b rst=%b want 0 0 1", bus.alu_result, bus.stat_out, bus.pc_rst); end
    rst_f = 1'b0;
    step(); step();
    total++; if (bus.ir_load !== 1'b1) begin bad++; $display("FAIL mid_reset_fetch got=%b want=1", bus.ir_load); end
  endtask

  task automatic test_halt();
    drive(32'hF0000000, 32'h0, 32'h0, 16'h0, 4'h0);
    step(); step();
    for (int k = 0; k < 6; k++) begin
      total++; if (bus.ir_load !== 1'b0 || bus.pc_write !== 1'b0 || bus.rf_we !== 1'b0 || bus.stat_en !== 1'b0) begin
        bad++; $display("FAIL halt_quiet[%0d] got ir=%b pw=%b we=%b en=%b want 0 0 0 0", k, bus.ir_load, bus.pc_write, bus.rf_we, bus.stat_en); end
      step();
    end
    rst_f = 1'b1;
    step();
    total++; if (bus.pc_rst !== 1'b1) begin bad++; $display("FAIL halt_reset got=%b want=1", bus.pc_rst); end
    rst_f = 1'b0;
    step(); step();
    total++; if (bus.ir_load !== 1'b1) begin bad++; $display("FAIL halt_restart got=%b want=1", bus.ir_load); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_swap();
    test_mid_reset();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
